// File: rtl/dcache_pkg.sv
// Shared types and defaults for the direct-mapped, write-through data cache.
package dcache_pkg;

  localparam int DATA_SIZE_DEF = 32;
  localparam int ADDR_W_DEF    = 16;
  localparam int INDEX_W_DEF   = 4;

  // Fixed encodings so the debug state bus stays stable across revisions.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_MISS = 2'd1;
  localparam logic [1:0] ST_WR_THRU = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    RD_MISS = ST_RD_MISS,
    WR_THRU = ST_WR_THRU
  } dcache_state_e;

  function automatic int tag_w(input int addr_w, input int index_w);
    return addr_w - index_w;
  endfunction

endpackage

// File: rtl/dcache_if.sv
// Memory-stage request/response and main-memory handshake bundle for m_dcache_ctrl.
interface dcache_if #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_W    = 16
) ();

  logic                 m_mem_read;
  logic                 m_mem_write;
  logic [ADDR_W-1:0]    m_addr;
  logic [DATA_SIZE-1:0] m_wdata;
  logic [DATA_SIZE-1:0] m_rdata;
  logic                 m_stall;
  logic                 m_wbwrite;
  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_SIZE-1:0] mem_wdata;
  logic [DATA_SIZE-1:0] mem_rdata;
  logic                 mem_ack;

  // Cache side.
  modport slave (
    input  m_mem_read, m_mem_write, m_addr, m_wdata, mem_rdata, mem_ack,
    output m_rdata, m_stall, m_wbwrite, mem_req, mem_we, mem_addr, mem_wdata
  );

  // Pipeline and memory environment side.
  modport master (
    output m_mem_read, m_mem_write, m_addr, m_wdata, mem_rdata, mem_ack,
    input  m_rdata, m_stall, m_wbwrite, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dcache_array.sv
// Valid/tag/data storage: async-cleared valids, combinational read, one write port.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int INDEX_W   = INDEX_W_DEF,
  parameter int TAG_W     = tag_w(ADDR_W_DEF, INDEX_W_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INDEX_W-1:0]   rd_index,
  output logic                 rd_valid,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [DATA_SIZE-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [INDEX_W-1:0]   wr_index,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 wr_set_valid
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]     valid_q;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [DATA_SIZE-1:0] data_q [LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en && wr_set_valid) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data hold whatever was last written; only valid bits are reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/m_dcache_ctrl.sv
// Memory-stage data cache controller (direct-mapped, write-through, no-write-allocate).
// Define DCACHE_STATS_EN to add saturating hit_cnt/miss_cnt read-lookup counters.
module m_dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int INDEX_W   = INDEX_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  dcache_if.slave    bus,
  output logic [1:0] dbg_state
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int TAG_W = tag_w(ADDR_W, INDEX_W);

  dcache_state_e        state;
  logic                 done;
  logic                 stall;
  logic                 mem_req_q;
  logic                 mem_we_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [DATA_SIZE-1:0] mem_wdata_q;

  logic [INDEX_W-1:0]   idx;
  logic [TAG_W-1:0]     tag;
  logic                 rd_valid;
  logic [TAG_W-1:0]     rd_tag;
  logic [DATA_SIZE-1:0] rd_data;
  logic                 wr_en;
  logic                 wr_set_valid;
  logic [INDEX_W-1:0]   wr_index;
  logic [TAG_W-1:0]     wr_tag;
  logic [DATA_SIZE-1:0] wr_data;

  logic hit, is_rd, wr_go, rd_hit, rd_miss;

  assign idx = bus.m_addr[INDEX_W-1:0];
  assign tag = bus.m_addr[ADDR_W-1:INDEX_W];

  dcache_array #(
    .DATA_SIZE(DATA_SIZE),
    .INDEX_W  (INDEX_W),
    .TAG_W    (TAG_W)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .rd_index    (idx),
    .rd_valid    (rd_valid),
    .rd_tag      (rd_tag),
    .rd_data     (rd_data),
    .wr_en       (wr_en),
    .wr_index    (wr_index),
    .wr_tag      (wr_tag),
    .wr_data     (wr_data),
    .wr_set_valid(wr_set_valid)
  );

  // A set write request wins over read; done masks the store still held for one cycle after its ack.
  assign hit     = rd_valid && (rd_tag == tag);
  assign is_rd   = bus.m_mem_read && !bus.m_mem_write;
  assign wr_go   = bus.m_mem_write && !done;
  assign rd_hit  = is_rd && hit;
  assign rd_miss = is_rd && !hit;

  always_comb begin
    stall = 1'b1;
    if (state == IDLE) stall = rd_miss || wr_go;
    if (rst)           stall = 1'b0;
  end

  always_comb begin
    wr_en        = 1'b0;
    wr_set_valid = 1'b0;
    wr_index     = idx;
    wr_tag       = tag;
    wr_data      = bus.m_wdata;
    if (state == RD_MISS && bus.mem_ack) begin
      wr_en        = 1'b1;
      wr_set_valid = 1'b1;
      wr_index     = mem_addr_q[INDEX_W-1:0];
      wr_tag       = mem_addr_q[ADDR_W-1:INDEX_W];
      wr_data      = bus.mem_rdata;
    end else if (state == IDLE && wr_go && hit) begin
      wr_en        = 1'b1;
      wr_set_valid = 1'b1;
    end
  end

  // Handshake: mem_req, mem_we, mem_addr, mem_wdata are registered and held steady from
  // request until the one-cycle mem_ack pulse; mem_req drops on the ack edge. Upstream
  // holds its request stable while m_stall = 1 and the transaction retires in the first
  // cycle m_stall = 0 (m_wbwrite = 1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      done        <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!stall) done <= 1'b0;
          if (wr_go) begin
            state       <= WR_THRU;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= bus.m_addr;
            mem_wdata_q <= bus.m_wdata;
          end else if (rd_miss) begin
            state      <= RD_MISS;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= bus.m_addr;
          end
        end
        RD_MISS, WR_THRU: begin
          if (bus.mem_ack) begin
            state     <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  // The first hit after a fill (done = 1) retires the miss and is not a new lookup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == IDLE) begin
      if (rd_hit && !done && hit_cnt != '1)  hit_cnt  <= hit_cnt + 32'd1;
      if (rd_miss && miss_cnt != '1)          miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

  assign bus.m_rdata   = (state == IDLE && rd_hit) ? rd_data : '0;
  assign bus.m_stall   = stall;
  assign bus.m_wbwrite = ~stall;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_m_dcache_ctrl.sv
// Directed scoreboard bench for m_dcache_ctrl with a fixed-latency (N=3) memory responder.
module tb_m_dcache_ctrl;
  import dcache_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  dbg_state;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int mem_req_starts = 0;
  int ack_delay = 3;

  logic [31:0] exp_q[$];
  logic [48:0] exp_mem_q[$];
  logic [31:0] mem_arr [logic [15:0]];

  dcache_if #(.DATA_SIZE(32), .ADDR_W(16)) bus ();

  m_dcache_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_state(dbg_state)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Load monitor: a load retires in the first non-stalled cycle.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.m_mem_read && !bus.m_mem_write && !bus.m_stall) begin
        if (exp_q.size() == 0) begin
          check("unexpected_load", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("load_data", bus.m_rdata, e);
          check("load_wbwrite", bus.m_wbwrite, 1);
        end
      end
    end
  end

  // Memory responder and request monitor.
  initial begin
    int cnt = 0;
    logic [48:0] e;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
      if (!bus.mem_req) begin
        cnt = 0;
      end else begin
        if (cnt == 0) begin
          mem_req_starts++;
          if (exp_mem_q.size() == 0) begin
            check("unexpected_mem_req", 1, 0);
          end else begin
            e = exp_mem_q.pop_front();
            if (e[48]) check("mem_write_req", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, e);
            else       check("mem_read_req", {bus.mem_we, bus.mem_addr}, e[48:32]);
          end
        end
        if (cnt == ack_delay) begin
          bus.mem_ack = 1'b1;
          if (bus.mem_we) mem_arr[bus.mem_addr] = bus.mem_wdata;
          else bus.mem_rdata = mem_arr.exists(bus.mem_addr) ? mem_arr[bus.mem_addr] : 32'h0;
        end
        cnt++;
      end
    end
  end

  // Driver tasks
  task automatic do_read(input logic [15:0] addr, input logic [31:0] exp_data,
                         input int exp_stall, input string name);
    int stalls = 0;
    bit ok = 0;
    exp_q.push_back(exp_data);
    if (exp_stall > 0) exp_mem_q.push_back({1'b0, addr, 32'h0});
    @(posedge clk); #1;
    bus.m_mem_read = 1'b1;
    bus.m_addr     = addr;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus.m_stall) begin ok = 1; break; end
      stalls++;
    end
    check({name, "_completes"}, ok, 1);
    check({name, "_stall_cycles"}, stalls, exp_stall);
    @(posedge clk); #1;
    bus.m_mem_read = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [31:0] data,
                          input bit also_read, input string name);
    int stalls = 0;
    bit ok = 0;
    bit rdata_nz = 0;
    exp_mem_q.push_back({1'b1, addr, data});
    @(posedge clk); #1;
    bus.m_mem_write = 1'b1;
    bus.m_mem_read  = also_read;
    bus.m_addr      = addr;
    bus.m_wdata     = data;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.m_rdata != 32'h0) rdata_nz = 1;
      if (!bus.m_stall) begin ok = 1; break; end
      stalls++;
    end
    check({name, "_completes"}, ok, 1);
    check({name, "_stall_cycles"}, stalls, 5);
    check({name, "_rdata_zero"}, rdata_nz, 0);
    @(posedge clk); #1;
    bus.m_mem_write = 1'b0;
    bus.m_mem_read  = 1'b0;
  endtask

  initial begin
    int s;
    bit ok;
    rst             = 1'b1;
    bus.m_mem_read  = 1'b0;
    bus.m_mem_write = 1'b0;
    bus.m_addr      = '0;
    bus.m_wdata     = '0;
    mem_arr[16'h0012] = 32'hDEADBEEF;
    mem_arr[16'h0112] = 32'hCAFEF00D;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mem_req",   bus.mem_req,   0);
    check("rst_mem_we",    bus.mem_we,    0);
    check("rst_mem_addr",  bus.mem_addr,  0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_m_stall",   bus.m_stall,   0);
    check("rst_m_wbwrite", bus.m_wbwrite, 1);
    check("rst_m_rdata",   bus.m_rdata,   0);
    check("rst_state",     dbg_state,     0);

    do_read(16'h0012, 32'hDEADBEEF, 5, "cold_read");
    s = mem_req_starts;
    do_read(16'h0012, 32'hDEADBEEF, 0, "warm_read");
    check("warm_no_mem_req", mem_req_starts, s);

    do_write(16'h0012, 32'h12345678, 0, "write_hit");
    s = mem_req_starts;
    do_read(16'h0012, 32'h12345678, 0, "read_after_write_hit");
    check("wr_hit_read_no_mem_req", mem_req_starts, s);

    do_write(16'h0033, 32'hA5A5A5A5, 0, "write_miss");
    do_read(16'h0033, 32'hA5A5A5A5, 5, "read_after_write_miss");

    do_write(16'h0055, 32'h0BADCAFE, 1, "read_and_write");

    do_read(16'h0012, 32'h12345678, 0, "alias_first");
    do_read(16'h0112, 32'hCAFEF00D, 5, "alias_second");
    do_read(16'h0012, 32'h12345678, 5, "alias_refetch");

    // Abort a fill part-way through with an asynchronous reset.
    exp_mem_q.push_back({1'b0, 16'h0112, 32'h0});
    @(posedge clk); #1;
    bus.m_mem_read = 1'b1;
    bus.m_addr     = 16'h0112;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dbg_state == 2'd1) begin ok = 1; break; end
    end
    check("abort_reached_rd_miss", ok, 1);
`ifdef DCACHE_STATS_EN
    check("stats_hits_before_reset",   hit_cnt,  3);
    check("stats_misses_before_reset", miss_cnt, 5);
`endif
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("abort_mem_req",   bus.mem_req,   0);
    check("abort_m_stall",   bus.m_stall,   0);
    check("abort_m_wbwrite", bus.m_wbwrite, 1);
    check("abort_state",     dbg_state,     0);
    bus.m_mem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    do_read(16'h0012, 32'h12345678, 5, "post_reset_read");
`ifdef DCACHE_STATS_EN
    check("stats_hits_final",   hit_cnt,  0);
    check("stats_misses_final", miss_cnt, 1);
`endif

    repeat (3) @(posedge clk);
    check("load_queue_drained", exp_q.size(), 0);
    check("mem_queue_drained",  exp_mem_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
